// File: rtl/credit_pkg.sv
// Shared definitions for the credit-based sender/receiver pair: default widths,
// the credit count type and the counter update operations.
package credit_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_MAX_CREDITS  = 4;
    localparam int DEFAULT_CREDIT_WIDTH = $clog2(DEFAULT_MAX_CREDITS + 1);

    typedef logic [DEFAULT_CREDIT_WIDTH-1:0] credit_t;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_DEC  = 2'd1,
        CNT_INC  = 2'd2
    } cnt_op_e;

endpackage

// File: rtl/credit_counter.sv
// Credit counter: spends one credit per transfer, adds one per return, saturates
// at MAX_CREDITS and raises a sticky error on an overflowing return.
module credit_counter
    import credit_pkg::*;
#(
    parameter int MAX_CREDITS  = DEFAULT_MAX_CREDITS,
    parameter int CREDIT_WIDTH = $clog2(MAX_CREDITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    receiver_in_reset,
    input  logic                    consume,
    input  logic                    credit_return,
    input  logic [CREDIT_WIDTH-1:0] credit_initial,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    credit_error
);

    localparam logic [CREDIT_WIDTH-1:0] MAX_COUNT = CREDIT_WIDTH'(MAX_CREDITS);

    function automatic logic [CREDIT_WIDTH-1:0] sat_initial(input logic [CREDIT_WIDTH-1:0] value);
        return (value > MAX_COUNT) ? MAX_COUNT : value;
    endfunction

    function automatic logic [CREDIT_WIDTH-1:0] sat_increment(input logic [CREDIT_WIDTH-1:0] value);
        return (value == MAX_COUNT) ? MAX_COUNT : value + CREDIT_WIDTH'(1);
    endfunction

    cnt_op_e op;

    // A transfer and a return in the same cycle cancel out.
    always_comb begin
        op = CNT_HOLD;
        if (consume && !credit_return) begin
            op = CNT_DEC;
        end else if (!consume && credit_return) begin
            op = CNT_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_count <= sat_initial(credit_initial);
            credit_error <= 1'b0;
        end else if (receiver_in_reset) begin
            credit_count <= sat_initial(credit_initial);
        end else begin
            case (op)
                CNT_DEC: credit_count <= credit_count - CREDIT_WIDTH'(1);
                CNT_INC: begin
                    credit_count <= sat_increment(credit_count);
                    if (credit_count == MAX_COUNT) begin
                        credit_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/credit_sender.sv
// Credit-based sender: accepts upstream words while credits remain and forwards
// them through a single registered pop stage with no downstream backpressure.
module credit_sender
    import credit_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int MAX_CREDITS  = DEFAULT_MAX_CREDITS,
    parameter int CREDIT_WIDTH = $clog2(MAX_CREDITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [DATA_WIDTH-1:0]   push_data,
    output logic                    pop_valid,
    output logic [DATA_WIDTH-1:0]   pop_data,
    input  logic                    pop_credit,
    output logic                    pop_sender_in_reset,
    input  logic                    pop_receiver_in_reset,
    input  logic [CREDIT_WIDTH-1:0] credit_initial,
    input  logic [CREDIT_WIDTH-1:0] credit_withhold,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    credit_available,
    output logic                    credit_error
);

    logic                  xfer_p0;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] pop_data_p1;

    // Availability uses only the registered count, so a returned credit is spendable next cycle.
    assign credit_available    = (credit_count > credit_withhold);
    assign push_ready          = credit_available && !pop_receiver_in_reset && !rst;
    assign xfer_p0             = push_valid && push_ready;
    assign pop_sender_in_reset = rst;

    credit_counter #(
        .MAX_CREDITS  (MAX_CREDITS),
        .CREDIT_WIDTH (CREDIT_WIDTH)
    ) u_counter (
        .clk               (clk),
        .rst               (rst),
        .receiver_in_reset (pop_receiver_in_reset),
        .consume           (xfer_p0),
        .credit_return     (pop_credit),
        .credit_initial    (credit_initial),
        .credit_count      (credit_count),
        .credit_error      (credit_error)
    );

    // Stage p0 -> p1: registered pop interface; xfer_p0 is already low during either reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            pop_data_p1 <= '0;
        end else begin
            vld_p1 <= xfer_p0;
            if (xfer_p0) begin
                pop_data_p1 <= push_data;
            end
        end
    end

    assign pop_valid = vld_p1;
    assign pop_data  = pop_data_p1;

endmodule

// File: tb/tb_credit_sender.sv
// Directed and randomized bench for credit_sender against a credit-arithmetic reference model.
module tb_credit_sender;

    localparam int DW   = 8;
    localparam int MAXC = 4;
    localparam int CW   = $clog2(MAXC + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic          pop_credit;
    logic          pop_sender_in_reset;
    logic          pop_receiver_in_reset;
    logic [CW-1:0] credit_initial;
    logic [CW-1:0] credit_withhold;
    logic [CW-1:0] credit_count;
    logic          credit_available;
    logic          credit_error;

    always #5 clk = ~clk;

    credit_sender #(
        .DATA_WIDTH  (DW),
        .MAX_CREDITS (MAXC),
        .CREDIT_WIDTH(CW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .push_valid            (push_valid),
        .push_ready            (push_ready),
        .push_data             (push_data),
        .pop_valid             (pop_valid),
        .pop_data              (pop_data),
        .pop_credit            (pop_credit),
        .pop_sender_in_reset   (pop_sender_in_reset),
        .pop_receiver_in_reset (pop_receiver_in_reset),
        .credit_initial        (credit_initial),
        .credit_withhold       (credit_withhold),
        .credit_count          (credit_count),
        .credit_available      (credit_available),
        .credit_error          (credit_error)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: credits as a plain integer, expected pop register contents.
    int            cred = 0;
    bit            err = 1'b0;
    bit            known = 1'b0;
    logic          exp_vld = 1'b0;
    logic [DW-1:0] exp_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int load_value(input logic [CW-1:0] v);
        return (int'(v) > MAXC) ? MAXC : int'(v);
    endfunction

    // Check outputs mid-cycle, then advance the model by one clock using the current inputs.
    task automatic tick();
        bit avail;
        bit ready;
        bit xfer;
        int nxt;
        @(negedge clk);
        avail = known && (cred > int'(credit_withhold));
        ready = avail && !pop_receiver_in_reset && !rst;
        check("sender_in_reset", 32'(pop_sender_in_reset), 32'(rst));
        check("push_ready", 32'(push_ready), 32'(ready));
        if (known) begin
            check("credit_count", 32'(credit_count), 32'(cred));
            check("credit_available", 32'(credit_available), 32'(avail));
            check("pop_valid", 32'(pop_valid), 32'(exp_vld));
            check("pop_data", 32'(pop_data), 32'(exp_data));
            check("credit_error", 32'(credit_error), 32'(err));
        end
        xfer = push_valid && ready;
        if (rst) begin
            cred     = load_value(credit_initial);
            err      = 1'b0;
            exp_vld  = 1'b0;
            exp_data = '0;
            known    = 1'b1;
        end else if (pop_receiver_in_reset) begin
            cred    = load_value(credit_initial);
            exp_vld = 1'b0;
        end else begin
            nxt = cred - int'(xfer) + int'(pop_credit);
            if (nxt > MAXC) begin
                nxt = MAXC;
                err = 1'b1;
            end
            cred    = nxt;
            exp_vld = xfer;
            if (xfer) exp_data = push_data;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                   = 1'b1;
        push_valid            = 1'b0;
        push_data             = '0;
        pop_credit            = 1'b0;
        pop_receiver_in_reset = 1'b0;
        credit_initial        = CW'(3);
        credit_withhold       = '0;
        tick();
        tick();

        // Burst from 3 credits drains to zero.
        rst        = 1'b0;
        push_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_data = DW'($urandom);
            tick();
        end
        check("burst_drained", 32'(credit_count), 32'd0);

        // A returned credit is usable only the cycle after it arrives.
        pop_credit = 1'b1;
        tick();
        pop_credit = 1'b0;
        push_valid = 1'b0;
        tick();
        check("return_count", 32'(credit_count), 32'd1);
        pop_credit = 1'b1;
        tick();
        pop_credit = 1'b0;
        tick();

        // Simultaneous transfer and return at count 2.
        push_valid = 1'b1;
        pop_credit = 1'b1;
        push_data  = 8'hA5;
        tick();
        push_valid = 1'b0;
        pop_credit = 1'b0;
        tick();
        check("simul_count", 32'(credit_count), 32'd2);

        // Overflowing return saturates and latches the error.
        pop_credit = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        pop_credit = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("error_sticky", 32'(credit_error), 32'd1);
        check("saturated_count", 32'(credit_count), 32'd4);

        // Withholding credits, then releasing them in the same cycle.
        credit_initial  = CW'(4);
        credit_withhold = CW'(3);
        rst             = 1'b1;
        tick();
        rst        = 1'b0;
        push_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_data = DW'($urandom);
            tick();
        end
        credit_withhold = '0;
        tick();
        push_valid = 1'b0;
        tick();

        // Reset during a transfer drops the in-flight word.
        push_valid = 1'b1;
        push_data  = 8'h3C;
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        push_valid = 1'b0;
        tick();
        check("reset_drop_valid", 32'(pop_valid), 32'd0);

        // Oversized initial credit loads as MAX_CREDITS.
        credit_initial = CW'(7);
        rst            = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("initial_clamped", 32'(credit_count), 32'd4);

        // Receiver reset mid-burst reloads the count and ignores returns.
        push_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_data = DW'($urandom);
            tick();
        end
        pop_receiver_in_reset = 1'b1;
        pop_credit            = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_data = DW'($urandom);
            tick();
        end
        pop_receiver_in_reset = 1'b0;
        pop_credit            = 1'b0;
        push_valid            = 1'b0;
        tick();
        tick();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst                   = ($urandom_range(0, 49) == 0);
            pop_receiver_in_reset = ($urandom_range(0, 29) == 0);
            push_valid            = 1'($urandom_range(0, 1));
            pop_credit            = ($urandom_range(0, 3) == 0);
            credit_withhold       = CW'($urandom_range(0, 2));
            push_data             = DW'($urandom);
            if (rst) credit_initial = CW'($urandom_range(0, 7));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/credit_sender.md
CREDIT_SENDER -- requirements
Module: credit_sender

Interface
REQ-001 Parameter: DATA_WIDTH, 8, payload width in bits.
REQ-002 Parameter: MAX_CREDITS, 4, largest credit count the counter holds.
REQ-003 Parameter: CREDIT_WIDTH, clog2(MAX_CREDITS+1), width of all credit-valued ports.
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: push_valid  input  1  upstream has a data word.
REQ-007 Port: push_ready  output  1  sender accepts the word this cycle.
REQ-008 Port: push_data  input  DATA_WIDTH  upstream payload.
REQ-009 Port: pop_valid  output  1  word sent to the credit receiver.
REQ-010 Port: pop_data  output  DATA_WIDTH  payload sent to the credit receiver.
REQ-011 Port: pop_credit  input  1  one credit returned by the receiver.
REQ-012 Port: pop_sender_in_reset  output  1  tells the receiver this side is in reset.
REQ-013 Port: pop_receiver_in_reset  input  1  receiver side is in reset.
REQ-014 Port: credit_initial  input  CREDIT_WIDTH  count loaded on reset; quasi-static.
REQ-015 Port: credit_withhold  input  CREDIT_WIDTH  credits held back from use.
REQ-016 Port: credit_count  output  CREDIT_WIDTH  current registered credit count.
REQ-017 Port: credit_available  output  1  a credit may be spent this cycle.
REQ-018 Port: credit_error  output  1  sticky flag for a credit return beyond MAX_CREDITS.

Function
REQ-019 credit_available SHALL equal (credit_count > credit_withhold), computed from the registered count only.
REQ-020 push_ready SHALL equal credit_available AND NOT pop_receiver_in_reset AND NOT rst.
REQ-021 A push transfer (push_valid AND push_ready) SHALL consume exactly one credit.
REQ-022 The next credit_count SHALL be count - push transfer + pop_credit; a simultaneous transfer and return SHALL leave the count unchanged.
REQ-023 A returned credit SHALL become usable in the cycle after pop_credit, with no combinational bypass.
REQ-024 If pop_credit arrives with credit_count == MAX_CREDITS and no transfer that cycle, the count SHALL saturate at MAX_CREDITS and credit_error SHALL set, staying set until rst.
REQ-025 pop_valid and pop_data SHALL be registered, giving one-cycle latency: a transfer in cycle N drives pop_valid=1 with that data in cycle N+1.
REQ-026 Without a transfer, pop_valid SHALL be 0 next cycle; pop_data SHALL hold its last value.
REQ-027 There SHALL be no backpressure on the pop side; the credit count alone guarantees the receiver can accept.
REQ-028 A credit_withhold change SHALL affect credit_available in the same cycle without altering credit_count.
REQ-029 pop_sender_in_reset SHALL equal rst combinationally.
REQ-030 While pop_receiver_in_reset is high, credit_count SHALL reload credit_initial every cycle, pop_valid SHALL register 0, and pop_credit SHALL be ignored.

Reset
REQ-031 On rst: credit_count <= credit_initial, pop_valid <= 0, pop_data <= 0, credit_error <= 0.
REQ-032 rst asserted mid-transfer SHALL drop any in-flight word: pop_valid is 0 in the cycle after the reset edge.
REQ-033 credit_initial greater than MAX_CREDITS SHALL load MAX_CREDITS.

Structure
REQ-034 A shared package credit_pkg SHALL hold the default DATA_WIDTH, the default MAX_CREDITS and a credit_t typedef, for use by both sender and receiver.
REQ-035 The count, saturation and error logic SHALL live in one sub-module, credit_counter; the pop register stage SHALL stay in the top level.

Verification
REQ-036 Reset with credit_initial=3, withhold=0, push_valid held 1 -> exactly 3 transfers, then push_ready=0 and credit_count=0; each pop_valid pulse appears one cycle after its transfer.
REQ-037 count=0, pop_credit pulse in cycle N -> credit_count=1 and push_ready=1 in cycle N+1, never in cycle N.
REQ-038 count=2 with a transfer and pop_credit in the same cycle -> count stays 2 and pop_valid=1 next cycle.
REQ-039 MAX_CREDITS=4, count=4, pop_credit=1 -> count stays 4 and credit_error=1 until rst.
REQ-040 credit_initial=4, withhold=3 -> one transfer, then push_ready=0; lowering withhold to 0 -> push_ready=1 the same cycle.
REQ-041 pop_receiver_in_reset asserted mid-burst with count=1 -> push_ready=0, pop_valid=0 next cycle, count=credit_initial until release.
